// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Brief    : Framed byte-stream loader that writes 32-bit words into the IM
//            and releases the CPU from reset only after a clean frame.
// Revision : 1.0  initial release
// ============================================================================
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          IM_WORDS  = 4096,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CNT   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [33:0] C_LIMIT = 34'(IM_WORDS) << 2;

  logic [2:0]  state_q,    state_d;
  logic [31:0] addr_q,     addr_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [1:0]  idx_q,      idx_d;
  logic [23:0] word_q,     word_d;
  logic [31:0] wptr_q,     wptr_d;
  logic [15:0] left_q,     left_d;
  logic [7:0]  csum_q,     csum_d;
  logic        we_q,       we_d;
  logic [31:0] waddr_q,    waddr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic        hold_q,     hold_d;
  logic        done_q,     done_d;
  logic        err_q,      err_d;

  logic        w_accept;
  logic [33:0] w_end_off;
  logic        w_range_bad;

  // Ready is a pure function of state, so the byte source never sees a loop.
  assign rx_ready = (state_q != S_CHECK) && (state_q != S_DONE);
  assign w_accept = rx_valid && rx_ready;

  // End offset of the frame in 34 bits so large counts cannot wrap past the limit.
  assign w_end_off   = ({2'b00, addr_q} - {2'b00, BASE_ADDR}) + {16'h0000, cnt_q, 2'b00};
  assign w_range_bad = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (w_end_off > C_LIMIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wptr_d  = wptr_q;
    left_d  = left_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept && (rx_data == SYNC_BYTE)) begin
          state_d = S_ADDR;
          idx_d   = 2'd0;
        end
      end
      S_ADDR: begin
        if (w_accept) begin
          addr_d = {addr_q[23:0], rx_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_CNT;
            idx_d   = 2'd0;
          end
        end
      end
      S_CNT: begin
        if (w_accept) begin
          cnt_d = {cnt_q[7:0], rx_data};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            state_d = S_CHECK;
            idx_d   = 2'd0;
          end
        end
      end
      S_CHECK: begin
        wptr_d = addr_q;
        left_d = cnt_q;
        csum_d = 8'h00;
        if (w_range_bad) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (cnt_q == 16'h0000) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          word_d = {word_q[15:0], rx_data};
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = {word_q, rx_data};
            wptr_d  = wptr_q + 32'd4;
            left_d  = left_q - 16'd1;
            if (left_q == 16'd1) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        // DONE and ERR are terminal; ERR keeps swallowing bytes.
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      cnt_q   <= 16'h0;
      idx_q   <= 2'd0;
      word_q  <= 24'h0;
      wptr_q  <= 32'h0;
      left_q  <= 16'h0;
      csum_q  <= 8'h00;
      we_q    <= 1'b0;
      waddr_q <= 32'h0;
      wdata_q <= 32'h0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wptr_q  <= wptr_d;
      left_q  <= left_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign im_we     = we_q;
  assign im_addr   = waddr_q;
  assign im_wdata  = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_loader
// Brief    : Directed self-checking bench for the framed IM loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_im_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int vectors;
  int miscompares;

  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int          wr_n;

  im_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, sampled on the falling edge; cleared while reset is held.
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_n = 0;
    end else if (im_we) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = im_addr;
        wr_data[wr_n] = im_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    guard = 0;
    while (!rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      miscompares++;
      $error("FAIL send_timeout: observed rx_ready=0 for 20 cycles expected 1");
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [15:0] n, input bit gaps);
    send(8'hA5, 0);
    send(a[31:24], gaps ? 1 : 0);
    send(a[23:16], gaps ? 2 : 0);
    send(a[15:8],  gaps ? 3 : 0);
    send(a[7:0],   0);
    send(n[15:8],  gaps ? 1 : 0);
    send(n[7:0],   gaps ? 2 : 0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send(w[31:24], gaps ? 3 : 0);
    send(w[23:16], 0);
    send(w[15:8],  gaps ? 1 : 0);
    send(w[7:0],   gaps ? 2 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_frame1(input string tag);
    check({tag, "_wr_n"},  wr_n,        32'd2);
    check({tag, "_a0"},    wr_addr[0],  32'h0000_3000);
    check({tag, "_d0"},    wr_data[0],  32'h2408_0001);
    check({tag, "_a1"},    wr_addr[1],  32'h0000_3004);
    check({tag, "_d1"},    wr_data[1],  32'h3C09_ABCD);
    check({tag, "_done"},  load_done,   32'd1);
    check({tag, "_err"},   load_err,    32'd0);
    check({tag, "_hold"},  cpu_hold,    32'd0);
    check({tag, "_ready"}, rx_ready,    32'd0);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err"},   load_err, 32'd1);
    check({tag, "_done"},  load_done, 32'd0);
    check({tag, "_hold"},  cpu_hold, 32'd1);
    check({tag, "_ready"}, rx_ready, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_ready", rx_ready,  32'd1);
    check("rst_we",    im_we,     32'd0);
    check("rst_addr",  im_addr,   32'h0);
    check("rst_wdata", im_wdata,  32'h0);
    check("rst_hold",  cpu_hold,  32'd1);
    check("rst_done",  load_done, 32'd0);
    check("rst_err",   load_err,  32'd0);

    // Basic two-word frame, checksum 0x7E.
    send_hdr(32'h0000_3000, 16'd2, 1'b0);
    send_word(32'h2408_0001, 1'b0);
    send_word(32'h3C09_ABCD, 1'b0);
    send(8'h7E, 0);
    repeat (2) @(negedge clk);
    check_frame1("f1");
    check("f1_im_addr",  im_addr,  32'h0000_3004);
    check("f1_im_wdata", im_wdata, 32'h3C09_ABCD);

    // Junk before sync, then the same frame with valid gaps.
    do_reset();
    send(8'h00, 0);
    send(8'hFF, 1);
    send(8'h12, 0);
    repeat (2) @(negedge clk);
    check("junk_wr_n", wr_n, 32'd0);
    send_hdr(32'h0000_3000, 16'd2, 1'b1);
    send_word(32'h2408_0001, 1'b1);
    send_word(32'h3C09_ABCD, 1'b1);
    send(8'h7E, 3);
    repeat (2) @(negedge clk);
    check_frame1("f2");

    // Misaligned address.
    do_reset();
    send_hdr(32'h0000_3002, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    check_err("misal");
    send_word(32'h2408_0001, 1'b0);
    send_word(32'h3C09_ABCD, 1'b0);
    send(8'h7E, 0);
    repeat (2) @(negedge clk);
    check("misal_wr_n", wr_n, 32'd0);
    check("misal_err2", load_err, 32'd1);

    // Below the text segment.
    do_reset();
    send_hdr(32'h0000_2FFC, 16'd1, 1'b0);
    repeat (3) @(negedge clk);
    check_err("low");
    check("low_wr_n", wr_n, 32'd0);

    // Runs one word past the end of IM.
    do_reset();
    send_hdr(32'h0000_6FFC, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    check_err("high");
    check("high_wr_n", wr_n, 32'd0);

    // Exactly the last word is legal; checksum DE^AD^BE^EF = 0x22.
    do_reset();
    send_hdr(32'h0000_6FFC, 16'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send(8'h22, 0);
    repeat (2) @(negedge clk);
    check("last_wr_n", wr_n,       32'd1);
    check("last_a0",   wr_addr[0], 32'h0000_6FFC);
    check("last_d0",   wr_data[0], 32'hDEAD_BEEF);
    check("last_done", load_done,  32'd1);
    check("last_hold", cpu_hold,   32'd0);

    // Bad checksum: writes still happen, frame rejected.
    do_reset();
    send_hdr(32'h0000_3000, 16'd2, 1'b0);
    send_word(32'h2408_0001, 1'b0);
    send_word(32'h3C09_ABCD, 1'b0);
    send(8'h7F, 0);
    repeat (2) @(negedge clk);
    check("bad_wr_n", wr_n,       32'd2);
    check("bad_d1",   wr_data[1], 32'h3C09_ABCD);
    check_err("bad");

    // Empty frame with matching and non-matching checksum.
    do_reset();
    send_hdr(32'h0000_3000, 16'd0, 1'b0);
    send(8'h00, 0);
    repeat (2) @(negedge clk);
    check("n0_wr_n", wr_n,      32'd0);
    check("n0_done", load_done, 32'd1);
    check("n0_hold", cpu_hold,  32'd0);
    do_reset();
    send_hdr(32'h0000_3000, 16'd0, 1'b0);
    send(8'h01, 0);
    repeat (2) @(negedge clk);
    check("n0bad_wr_n", wr_n, 32'd0);
    check_err("n0bad");

    // Reset asserted after the second data byte aborts the frame.
    do_reset();
    send_hdr(32'h0000_3000, 16'd2, 1'b0);
    send(8'h24, 0);
    send(8'h08, 0);
    check("abort_pre_wr_n", wr_n, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_ready", rx_ready,  32'd1);
    check("abort_we",    im_we,     32'd0);
    check("abort_addr",  im_addr,   32'h0);
    check("abort_wdata", im_wdata,  32'h0);
    check("abort_hold",  cpu_hold,  32'd1);
    check("abort_done",  load_done, 32'd0);
    check("abort_err",   load_err,  32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'h01, 0);
    send(8'h3C, 0);
    repeat (2) @(negedge clk);
    check("abort_tail_wr_n", wr_n, 32'd0);
    send_hdr(32'h0000_3000, 16'd2, 1'b0);
    send_word(32'h2408_0001, 1'b0);
    send_word(32'h3C09_ABCD, 1'b0);
    send(8'h7E, 0);
    repeat (2) @(negedge clk);
    check_frame1("f6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
